// File: rtl/sram_like_resp_if.sv
// Request/response bundle of the sram-like req/addr_ok/data_ok port.
// The core drives the master side; the memory responder sits on the slave side.
interface sram_like_resp_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_resp.sv
// Sram-like responder over a 1-cycle-latency synchronous RAM, in-order responses.
// Define SRAM_LIKE_RAND_DELAY_EN to replace the fixed handshake delays with LFSR-driven ones.
module sram_like_resp #(
    parameter int          AW         = 16,
    parameter int          DEPTH      = 2,
    parameter int          ADDR_DELAY = 0,
    parameter int          DATA_DELAY = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              resetn,
    sram_like_resp_if.slave   bus,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 2) + 1;

    logic [31:0]   fifo_r [DEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] occ_s;
    logic          inflight_r;
    logic          inflight_wr_r;
    logic [3:0]    acnt_r;
    logic [3:0]    dcnt_r;
    logic [3:0]    athr_s;
    logic [3:0]    dthr_s;
    logic          accept_s;
    logic          pop_s;
    logic          empty_s;
    logic          addr_unused_s;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    assign addr_unused_s = ^{bus.size, bus.addr[31:AW+2], bus.addr[1:0]};

`ifdef SRAM_LIKE_RAND_DELAY_EN
    logic [15:0] lfsr_r;
    logic [3:0]  athr_r;
    logic [3:0]  dthr_r;

    assign athr_s = athr_r;
    assign dthr_s = dthr_r;

    // Free-running LFSR; thresholds reload whenever their counter clears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_r <= LFSR_SEED;
            athr_r <= 4'd0;
            dthr_r <= 4'd0;
        end else begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
            athr_r <= accept_s ? {2'b00, lfsr_r[1:0]} : athr_r;
            dthr_r <= (pop_s || empty_s) ? {2'b00, lfsr_r[3:2]} : dthr_r;
        end
    end
`else
    assign athr_s = 4'(ADDR_DELAY);
    assign dthr_s = 4'(DATA_DELAY);
`endif

    // Handshake decode; occupancy is taken before this cycle's pop frees a slot.
    always_comb begin
        occ_s       = cnt_r + CW'(inflight_r);
        empty_s     = (cnt_r == {CW{1'b0}});
        bus.addr_ok = resetn && bus.req && (occ_s < CW'(DEPTH)) && (acnt_r >= athr_s);
        accept_s    = bus.req && bus.addr_ok;
        pop_s       = !empty_s && (dcnt_r >= dthr_s);
        bus.data_ok = pop_s;
        bus.rdata   = pop_s ? fifo_r[rptr_r] : 32'h0;
        ram_en      = accept_s;
        ram_we      = (accept_s && bus.wr) ? bus.wstrb : 4'b0000;
        ram_addr    = bus.addr[AW+1:2];
        ram_wdata   = bus.wdata;
    end

    // Response FIFO, one-cycle RAM pipeline stage and delay counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= 32'h0;
            end
            wptr_r        <= {PW{1'b0}};
            rptr_r        <= {PW{1'b0}};
            cnt_r         <= {CW{1'b0}};
            inflight_r    <= 1'b0;
            inflight_wr_r <= 1'b0;
            acnt_r        <= 4'd0;
            dcnt_r        <= 4'd0;
        end else begin
            inflight_r    <= accept_s;
            inflight_wr_r <= accept_s && bus.wr;
            if (inflight_r) begin
                fifo_r[wptr_r] <= inflight_wr_r ? 32'h0 : ram_rdata;
                wptr_r         <= nxt_ptr(wptr_r);
            end else begin
                wptr_r <= wptr_r;
            end
            rptr_r <= pop_s ? nxt_ptr(rptr_r) : rptr_r;
            case ({inflight_r, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
            if (accept_s) begin
                acnt_r <= 4'd0;
            end else if (bus.req && (acnt_r != 4'd15)) begin
                acnt_r <= acnt_r + 4'd1;
            end else begin
                acnt_r <= acnt_r;
            end
            if (pop_s || empty_s) begin
                dcnt_r <= 4'd0;
            end else if (dcnt_r != 4'd15) begin
                dcnt_r <= dcnt_r + 4'd1;
            end else begin
                dcnt_r <= dcnt_r;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_resp.sv
// Bench for sram_like_resp: directed handshake timing on three configurations
// plus a randomized in-order scoreboard run against a behavioural memory.
module tb_sram_like_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n, rst_c_n;
    sram_like_resp_if bus_a();
    sram_like_resp_if bus_b();
    sram_like_resp_if bus_c();

    logic        ram_en_a, ram_en_b, ram_en_c;
    logic [3:0]  ram_we_a, ram_we_b, ram_we_c;
    logic [15:0] ram_addr_a, ram_addr_b, ram_addr_c;
    logic [31:0] ram_wdata_a, ram_wdata_b, ram_wdata_c;
    logic [31:0] ram_rdata_a, ram_rdata_b, ram_rdata_c;

    int checks = 0;
    int errors = 0;

    sram_like_resp #(.AW(16), .DEPTH(2), .ADDR_DELAY(0), .DATA_DELAY(0), .LFSR_SEED(16'hACE1)) dut_a (
        .clk(clk), .resetn(rst_a_n), .bus(bus_a), .ram_en(ram_en_a), .ram_we(ram_we_a),
        .ram_addr(ram_addr_a), .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a));
    sram_like_resp #(.AW(16), .DEPTH(2), .ADDR_DELAY(0), .DATA_DELAY(3), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .resetn(rst_b_n), .bus(bus_b), .ram_en(ram_en_b), .ram_we(ram_we_b),
        .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b));
    sram_like_resp #(.AW(16), .DEPTH(2), .ADDR_DELAY(2), .DATA_DELAY(0), .LFSR_SEED(16'hACE1)) dut_c (
        .clk(clk), .resetn(rst_c_n), .bus(bus_c), .ram_en(ram_en_c), .ram_we(ram_we_c),
        .ram_addr(ram_addr_c), .ram_wdata(ram_wdata_c), .ram_rdata(ram_rdata_c));

    // Byte-writable RAM behind dut_a, with a backdoor load port
    logic [31:0] mem_a [65536];
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [31:0] ld_data = 32'h0;
    always @(posedge clk) begin
        if (ld_en) begin
            mem_a[ld_addr] <= ld_data;
        end else if (ram_en_a) begin
            for (int b = 0; b < 4; b++)
                if (ram_we_a[b]) mem_a[ram_addr_a][8*b +: 8] <= ram_wdata_a[8*b +: 8];
            ram_rdata_a <= mem_a[ram_addr_a];
        end
    end

    // Address-tagged ROMs behind dut_b and dut_c
    always @(posedge clk) if (ram_en_b) ram_rdata_b <= {16'hBEEF, ram_addr_b};
    always @(posedge clk) if (ram_en_c) ram_rdata_c <= {16'hBEEF, ram_addr_c};

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic load_a(input logic [15:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        next_cycle();
        ld_en = 1'b0;
    endtask

    task automatic test_reset();
        bus_a.req = 1'b1; bus_a.addr = 32'h10;
        @(negedge clk);
        checks++; if (bus_a.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got %b want 0", bus_a.addr_ok); end
        checks++; if (bus_a.data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got %b want 0", bus_a.data_ok); end
        checks++; if (bus_a.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus_a.rdata); end
        bus_a.req = 1'b0;
        next_cycle();
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
        @(negedge clk);
        checks++; if (bus_a.data_ok !== 1'b0) begin errors++; $display("FAIL post_reset_data_ok got %b want 0", bus_a.data_ok); end
        next_cycle();
    endtask

    task automatic test_single_read();
        load_a(16'h4, 32'h1234_5678);
        bus_a.req = 1'b1; bus_a.wr = 1'b0; bus_a.addr = 32'h10; bus_a.wstrb = 4'h0; bus_a.size = 2'd2;
        @(negedge clk);
        checks++; if (!(bus_a.addr_ok === 1'b1 && ram_en_a === 1'b1 && ram_addr_a === 16'h4 && ram_we_a === 4'h0)) begin
            errors++; $display("FAIL read_accept got ok=%b en=%b a=%h we=%b want 1 1 0004 0000", bus_a.addr_ok, ram_en_a, ram_addr_a, ram_we_a); end
        next_cycle(); bus_a.req = 1'b0;
        @(negedge clk);
        checks++; if (bus_a.data_ok !== 1'b0 || ram_en_a !== 1'b0) begin errors++; $display("FAIL read_t1 got dok=%b en=%b want 0 0", bus_a.data_ok, ram_en_a); end
        next_cycle(); @(negedge clk);
        checks++; if (bus_a.data_ok !== 1'b1 || bus_a.rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL read_t2 got dok=%b rdata=%h want 1 12345678", bus_a.data_ok, bus_a.rdata); end
        next_cycle(); @(negedge clk);
        checks++; if (bus_a.data_ok !== 1'b0 || bus_a.rdata !== 32'h0) begin errors++; $display("FAIL read_t3 got dok=%b rdata=%h want 0 0", bus_a.data_ok, bus_a.rdata); end
        next_cycle();
    endtask

    task automatic test_byte_write();
        load_a(16'h8, 32'h1122_3344);
        bus_a.req = 1'b1; bus_a.wr = 1'b1; bus_a.addr = 32'h20; bus_a.wstrb = 4'b0100; bus_a.wdata = 32'h00AB_0000;
        @(negedge clk);
        checks++; if (bus_a.addr_ok !== 1'b1 || ram_we_a !== 4'b0100) begin errors++; $display("FAIL bw_accept got ok=%b we=%b want 1 0100", bus_a.addr_ok, ram_we_a); end
        next_cycle(); bus_a.req = 1'b0; bus_a.wr = 1'b0;
        next_cycle(); @(negedge clk);
        checks++; if (bus_a.data_ok !== 1'b1 || bus_a.rdata !== 32'h0) begin errors++; $display("FAIL bw_resp got dok=%b rdata=%h want 1 0", bus_a.data_ok, bus_a.rdata); end
        next_cycle();
        bus_a.req = 1'b1; bus_a.addr = 32'h20;
        next_cycle(); bus_a.req = 1'b0;
        next_cycle(); @(negedge clk);
        checks++; if (bus_a.data_ok !== 1'b1 || bus_a.rdata !== 32'h11AB_3344) begin
            errors++; $display("FAIL bw_readback got dok=%b rdata=%h want 1 11ab3344", bus_a.data_ok, bus_a.rdata); end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        int stray;
        bus_a.req = 1'b1; bus_a.wr = 1'b0; bus_a.addr = 32'h10;
        next_cycle();
        bus_a.addr = 32'h20;
        @(negedge clk);
        checks++; if (bus_a.addr_ok !== 1'b1) begin errors++; $display("FAIL mid_second_accept got %b want 1", bus_a.addr_ok); end
        #2 rst_a_n = 1'b0;
        #1;
        checks++; if (bus_a.addr_ok !== 1'b0 || bus_a.data_ok !== 1'b0) begin
            errors++; $display("FAIL mid_reset_drop got ok=%b dok=%b want 0 0", bus_a.addr_ok, bus_a.data_ok); end
        bus_a.req = 1'b0;
        next_cycle(); next_cycle();
        rst_a_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); if (bus_a.data_ok === 1'b1) stray++;
            next_cycle();
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL mid_stray_data_ok got %0d want 0", stray); end
        bus_a.req = 1'b1; bus_a.addr = 32'h10;
        next_cycle(); bus_a.req = 1'b0;
        next_cycle(); @(negedge clk);
        checks++; if (bus_a.data_ok !== 1'b1 || bus_a.rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL mid_new_read got dok=%b rdata=%h want 1 12345678", bus_a.data_ok, bus_a.rdata); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        int acc_cyc[$]; int dok_cyc[$]; logic [31:0] dok_dat[$];
        int exp_acc[3] = '{0, 1, 6};
        int exp_dok[3] = '{5, 9, 13};
        int nacc = 0;
        bus_b.wr = 1'b0; bus_b.wstrb = 4'h0; bus_b.wdata = 32'h0; bus_b.size = 2'd2;
        for (int k = 0; k < 16; k++) begin
            bus_b.req = (nacc < 3); bus_b.addr = 32'h100 + 32'(4 * nacc);
            @(negedge clk);
            if (bus_b.req && bus_b.addr_ok) begin acc_cyc.push_back(k); nacc++; end
            if (bus_b.data_ok) begin dok_cyc.push_back(k); dok_dat.push_back(bus_b.rdata); end
            next_cycle();
        end
        bus_b.req = 1'b0;
        checks++; if (acc_cyc.size() != 3 || dok_cyc.size() != 3) begin
            errors++; $display("FAIL bp_counts got acc=%0d dok=%0d want 3 3", acc_cyc.size(), dok_cyc.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++; if ((i < acc_cyc.size() ? acc_cyc[i] : -1) != exp_acc[i]) begin
                errors++; $display("FAIL bp_accept_cycle[%0d] got %0d want %0d", i, (i < acc_cyc.size() ? acc_cyc[i] : -1), exp_acc[i]); end
            checks++; if ((i < dok_cyc.size() ? dok_cyc[i] : -1) != exp_dok[i]) begin
                errors++; $display("FAIL bp_data_ok_cycle[%0d] got %0d want %0d", i, (i < dok_cyc.size() ? dok_cyc[i] : -1), exp_dok[i]); end
            checks++; if ((i < dok_dat.size() ? dok_dat[i] : 32'h0) !== (32'hBEEF_0040 + 32'(i))) begin
                errors++; $display("FAIL bp_rdata[%0d] got %h want %h", i, (i < dok_dat.size() ? dok_dat[i] : 32'h0), 32'hBEEF_0040 + 32'(i)); end
        end
    endtask

    task automatic test_addr_delay();
        int acc_cyc[$]; int dok_cyc[$];
        int exp_acc[2] = '{2, 5};
        int exp_dok[2] = '{4, 7};
        int nacc = 0;
        bus_c.wr = 1'b0; bus_c.wstrb = 4'h0; bus_c.wdata = 32'h0; bus_c.size = 2'd2;
        for (int k = 0; k < 10; k++) begin
            bus_c.req = (nacc < 2); bus_c.addr = 32'h100 + 32'(4 * nacc);
            @(negedge clk);
            if (bus_c.req && bus_c.addr_ok) begin acc_cyc.push_back(k); nacc++; end
            if (bus_c.data_ok) dok_cyc.push_back(k);
            next_cycle();
        end
        bus_c.req = 1'b0;
        checks++; if (acc_cyc.size() != 2 || dok_cyc.size() != 2) begin
            errors++; $display("FAIL ad_counts got acc=%0d dok=%0d want 2 2", acc_cyc.size(), dok_cyc.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++; if ((i < acc_cyc.size() ? acc_cyc[i] : -1) != exp_acc[i]) begin
                errors++; $display("FAIL ad_accept_cycle[%0d] got %0d want %0d", i, (i < acc_cyc.size() ? acc_cyc[i] : -1), exp_acc[i]); end
            checks++; if ((i < dok_cyc.size() ? dok_cyc[i] : -1) != exp_dok[i]) begin
                errors++; $display("FAIL ad_data_ok_cycle[%0d] got %0d want %0d", i, (i < dok_cyc.size() ? dok_cyc[i] : -1), exp_dok[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [64];
        logic [31:0] expq[$];
        logic [31:0] exp_d;
        int acc = 0; int resp = 0; int cyc = 0;
        logic drop;
        int w;
        for (int i = 16; i < 48; i++) begin
            ref_mem[i] = $urandom;
            load_a(16'(i), ref_mem[i]);
        end
        bus_a.req = 1'b0;
        while (cyc < 30000 && (acc < 1000 || expq.size() != 0)) begin
            if (!bus_a.req && acc < 1000 && $urandom_range(0, 3) != 0) begin
                bus_a.req   = 1'b1;
                bus_a.wr    = 1'($urandom_range(0, 1));
                bus_a.addr  = {24'h0, 6'($urandom_range(16, 47)), 2'b00};
                bus_a.wstrb = 4'($urandom);
                bus_a.wdata = $urandom;
                bus_a.size  = 2'd2;
            end
            @(negedge clk);
            drop = 1'b0;
            if (bus_a.req && bus_a.addr_ok) begin
                w = int'(bus_a.addr[7:2]);
                if (bus_a.wr) begin
                    for (int b = 0; b < 4; b++)
                        if (bus_a.wstrb[b]) ref_mem[w][8*b +: 8] = bus_a.wdata[8*b +: 8];
                    expq.push_back(32'h0);
                end else begin
                    expq.push_back(ref_mem[w]);
                end
                acc++; drop = 1'b1;
            end
            if (bus_a.data_ok) begin
                exp_d = (expq.size() != 0) ? expq.pop_front() : 32'hDEAD_DEAD;
                resp++;
                checks++; if (bus_a.rdata !== exp_d) begin errors++; $display("FAIL rnd_rdata resp %0d got %h want %h", resp, bus_a.rdata, exp_d); end
            end else begin
                checks++; if (bus_a.rdata !== 32'h0) begin errors++; $display("FAIL rnd_idle_rdata got %h want 0", bus_a.rdata); end
            end
            checks++; if (acc - resp > 2 || acc - resp < 0) begin errors++; $display("FAIL rnd_occupancy got %0d want 0..2", acc - resp); end
            next_cycle();
            if (drop) bus_a.req = 1'b0;
            cyc++;
        end
        checks++; if (acc != 1000 || resp != 1000) begin errors++; $display("FAIL rnd_totals got acc=%0d resp=%0d want 1000 1000", acc, resp); end
        repeat (4) begin
            @(negedge clk);
            checks++; if (bus_a.data_ok !== 1'b0) begin errors++; $display("FAIL rnd_extra_data_ok got 1 want 0"); end
            next_cycle();
        end
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        bus_a.req = 1'b0; bus_a.wr = 1'b0; bus_a.size = 2'd2; bus_a.wstrb = 4'h0; bus_a.addr = 32'h0; bus_a.wdata = 32'h0;
        bus_b.req = 1'b0; bus_b.wr = 1'b0; bus_b.size = 2'd2; bus_b.wstrb = 4'h0; bus_b.addr = 32'h0; bus_b.wdata = 32'h0;
        bus_c.req = 1'b0; bus_c.wr = 1'b0; bus_c.size = 2'd2; bus_c.wstrb = 4'h0; bus_c.addr = 32'h0; bus_c.wdata = 32'h0;
        repeat (2) next_cycle();
        test_reset();
`ifndef SRAM_LIKE_RAND_DELAY_EN
        test_single_read();
        test_byte_write();
        test_reset_midflight();
        test_backpressure();
        test_addr_delay();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
